// File: rtl/pmd85_pkg.sv
// Shared types and constants for the PMD 85 ROM-pack loader.
// Holds the loader state encoding and the default erased-EPROM pad byte.
package pmd85_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } rompack_state_t;

    localparam logic [7:0] ROM_FILL = 8'hFF;

endpackage

// File: rtl/rompack_loader_if.sv
// ioctl download bus plus ROM-pack memory write bus seen by the loader.
// Ports: ioctl_download/wr/addr/dout/index/wait (HPS side),
//        mem_we/slot/addr/data/wait (memory side).
// Modport slave is the loader; modport master is the HPS plus memory.
interface rompack_loader_if #(
    parameter int unsigned SLOT_W = 1,
    parameter int unsigned ADDR_W = 14
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_dout;
    logic [7:0]        ioctl_index;
    logic              ioctl_wait;

    logic              mem_we;
    logic [SLOT_W-1:0] mem_slot;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_wait;

    modport slave (
        input  ioctl_download,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  ioctl_index,
        output ioctl_wait,
        output mem_we,
        output mem_slot,
        output mem_addr,
        output mem_data,
        input  mem_wait
    );

    modport master (
        output ioctl_download,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_index,
        input  ioctl_wait,
        input  mem_we,
        input  mem_slot,
        input  mem_addr,
        input  mem_data,
        output mem_wait
    );

endinterface

// File: rtl/rompack_loader.sv
// Multi-slot ROM-pack loader: ioctl bytes into slots, pads tails with FILL.
// Ports: clk_sys, reset (async high), bus (rompack_loader_if.slave),
//        busy, slot_valid, overflow, last_len.
module rompack_loader
    import pmd85_pkg::*;
#(
    parameter int unsigned SLOTS      = 2,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned BASE_INDEX = 1,
    parameter logic [7:0]  FILL       = ROM_FILL
) (
    input  logic              clk_sys,
    input  logic              reset,
    rompack_loader_if.slave   bus,
    output logic              busy,
    output logic [SLOTS-1:0]  slot_valid,
    output logic              overflow,
    output logic [ADDR_W:0]   last_len
);

    localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [ADDR_W:0] SIZE = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    rompack_state_t    state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ADDR_W:0]   hw_q, hw_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic              dl_q;

    logic              we_q, we_d;
    logic [SLOT_W-1:0] wslot_q, wslot_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic              room;
    logic              dl_rise;
    logic              addr_fits;
    logic [ADDR_W:0]   addr_next;
    logic [8:0]        idx_off;
    logic              idx_hit;
    logic [SLOT_W-1:0] idx_slot;

    // The output register can take a new write when it is empty or
    // its current write is retiring in this same cycle.
    assign room      = ~we_q | ~bus.mem_wait;
    assign dl_rise   = bus.ioctl_download & ~dl_q;
    assign addr_fits = (bus.ioctl_addr[24:ADDR_W] == '0);
    assign addr_next = {1'b0, bus.ioctl_addr[ADDR_W-1:0]} + ONE;
    assign idx_off   = {1'b0, bus.ioctl_index} - 9'(BASE_INDEX);
    assign idx_hit   = ({1'b0, bus.ioctl_index} >= 9'(BASE_INDEX))
                     && (idx_off < 9'(SLOTS));
    assign idx_slot  = idx_off[SLOT_W-1:0];

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        hw_d    = hw_q;
        fill_d  = fill_q;
        ovf_d   = ovf_q;
        len_d   = len_q;
        valid_d = valid_q;
        we_d    = we_q & bus.mem_wait;
        wslot_d = wslot_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (dl_rise && idx_hit) begin
                    state_d           = S_LOAD;
                    slot_d            = idx_slot;
                    valid_d[idx_slot] = 1'b0;
                    ovf_d             = 1'b0;
                    hw_d              = '0;
                end
            end
            S_LOAD: begin
                if (bus.ioctl_wr) begin
                    if (!addr_fits || !room) begin
                        ovf_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        wslot_d = slot_q;
                        waddr_d = bus.ioctl_addr[ADDR_W-1:0];
                        wdata_d = bus.ioctl_dout;
                        if (addr_next > hw_q) begin
                            hw_d = addr_next;
                        end
                    end
                end else if (!bus.ioctl_download && room) begin
                    // A byte strobed with the falling download keeps us
                    // here one more cycle, so it lands before the pad.
                    if (hw_q == SIZE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FILL;
                        fill_d  = hw_q[ADDR_W-1:0];
                    end
                end
            end
            S_FILL: begin
                if (room) begin
                    we_d    = 1'b1;
                    wslot_d = slot_q;
                    waddr_d = fill_q;
                    wdata_d = FILL;
                    fill_d  = fill_q + ADDR_W'(1);
                    if (fill_q == '1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                len_d           = hw_q;
                valid_d[slot_q] = (hw_q != '0);
                state_d         = S_IDLE;
            end
        endcase
    end

    // dl_q resets high so a download already running at reset release
    // never looks like a fresh rising edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            hw_q    <= '0;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
            len_q   <= '0;
            valid_q <= '0;
            dl_q    <= 1'b1;
            we_q    <= 1'b0;
            wslot_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            hw_q    <= hw_d;
            fill_q  <= fill_d;
            ovf_q   <= ovf_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            dl_q    <= bus.ioctl_download;
            we_q    <= we_d;
            wslot_q <= wslot_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.mem_we     = we_q;
    assign bus.mem_slot   = wslot_q;
    assign bus.mem_addr   = waddr_q;
    assign bus.mem_data   = wdata_q;
    assign bus.ioctl_wait = we_q & bus.mem_wait;

    assign busy       = (state_q != S_IDLE);
    assign slot_valid = valid_q;
    assign overflow   = ovf_q;
    assign last_len   = len_q;

endmodule

// File: doc/rompack_loader.md
# rompack_loader

Parametrised multi-slot ROM-pack loader between `hps_io` ioctl download signals and the core's ROM-pack memory. Accepts downloads for `SLOTS` consecutive OSD file indices and writes each byte into the matching slot. Pads the unused tail of the slot with a fill byte and reports the length and overflow of every load. Honours memory back-pressure by stalling the HPS through `ioctl_wait`.

## Interface
- `SLOTS`, default 2: number of ROM-pack slots (1..8).
- `ADDR_W`, default 14: byte-address width per slot; slot size is 2^ADDR_W.
- `BASE_INDEX`, default 1: `ioctl_index` served by slot 0.
- `FILL`, default 8'hFF: pad byte (erased EPROM).
- `clk_sys` in 1: system clock. One clock domain; all logic uses this clock.
- `reset` in 1: asynchronous, active-high reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: single-cycle byte strobe.
- `ioctl_addr` in 25: byte address within the file.
- `ioctl_dout` in 8: byte data.
- `ioctl_index` in 8: OSD file index.
- `ioctl_wait` out 1: stalls the HPS.
- `mem_we` out 1: write request.
- `mem_slot` out `$clog2(SLOTS)` (minimum 1): target slot.
- `mem_addr` out ADDR_W: byte address within the slot.
- `mem_data` out 8: write data.
- `mem_wait` in 1: memory not ready; the current write is held.
- `busy` out 1: loader is not in IDLE; the core holds the CPU in reset while this is high.
- `slot_valid` out SLOTS: the slot holds a completed, non-empty image.
- `overflow` out 1: the last load contained bytes at or above 2^ADDR_W.
- `last_len` out ADDR_W+1: high-water mark of the last load.

## Operation
- **States:** IDLE, LOAD, FILL, DONE. Encoded as 2 bits.
- **IDLE → LOAD:**
  - Trigger: `ioctl_download` rises and `ioctl_index` is in BASE_INDEX..BASE_INDEX+SLOTS-1.
  - Actions: latch `slot = index-BASE_INDEX`; clear `slot_valid[slot]`; clear `overflow`; clear high-water `hw`.
  - Downloads for other indices are ignored entirely.
- **LOAD, per `ioctl_wr` with `ioctl_addr < 2^ADDR_W`:**
  - Issue a write with `mem_addr = ioctl_addr[ADDR_W-1:0]` and `mem_data = ioctl_dout`.
  - `hw = max(hw, ioctl_addr+1)`.
- **LOAD, per `ioctl_wr` with `ioctl_addr ≥ 2^ADDR_W`:** drop the byte and set `overflow`.
- **LOAD → FILL:** on the `ioctl_download` falling edge, once any pending write has retired.
  - FILL writes `FILL` to addresses `hw`..2^ADDR_W-1, one per accepted cycle.
  - If `hw = 2^ADDR_W`, go straight to DONE.
- **DONE:**
  - Set `last_len = hw`.
  - Set `slot_valid[slot]` only if `hw != 0`; a zero-length load fills the whole slot and leaves it invalid.
  - Return to IDLE after 1 cycle.
- **Write handshake:**
  - A write is held in a one-entry output register. `mem_we`, `mem_addr` and `mem_data` stay stable while `mem_we & mem_wait`.
  - `ioctl_wait` is high whenever the register is occupied and `mem_wait` is high.
  - An `ioctl_wr` arriving while the register is full is a protocol violation and is dropped with `overflow` set.
- **Simultaneous events:**
  - `ioctl_wr` in the same cycle as the download falls: the byte is written before FILL starts.
  - A new download rising during FILL or DONE: ignored, and its writes are dropped. `busy` stays high, so the HPS-side core remains held.
- **Reset at any time:**
  - All outputs go to 0 and the state goes to IDLE.
  - `slot_valid` is cleared and memory contents are undefined.
  - A download in progress at reset release is not picked up, because no rising edge is seen.

## Timing
- **Reset values:** `mem_we`, `mem_addr`, `mem_data`, `mem_slot`, `ioctl_wait`, `busy`, `slot_valid`, `overflow` and `last_len` are all 0.
- **Write latency:** `mem_we` asserts exactly 1 `clk_sys` after `ioctl_wr` when `mem_wait` = 0.
- **`busy`:** rises 1 cycle after the qualifying download rise. Falls 1 cycle after DONE.
- **FILL duration:** 2^ADDR_W − `hw` cycles with no wait, plus one cycle per `mem_wait` stall.
- **`slot_valid` and `last_len`:** update in the DONE cycle and are visible the next cycle.
- **Arithmetic:** `hw` is ADDR_W+1 bits and saturates at 2^ADDR_W. Comparisons against `ioctl_addr` use the full 25 bits.

## Structure
- Shared package `pmd85_pkg` holds:
  - the `rompack_state_t` enum (IDLE, LOAD, FILL, DONE);
  - the default pad byte constant `ROM_FILL` = 8'hFF.
- Single flat module; no sub-module.
- Memory instantiation stays in the core, keyed on `mem_slot`.

## Test plan
Bench parameters: SLOTS=2, ADDR_W=4 (16-byte slots), BASE_INDEX=1.

- **Normal load with fill:** index 2, bytes 0..9 = 8'hA0+i, no wait.
  - Writes slot 1 at addresses 0..9, then FILL at 10..15.
  - Ends with `last_len` = 10, `slot_valid` = 2'b10, `overflow` = 0.
- **Oversize file:** index 1, 20 bytes.
  - Addresses 0..15 written, bytes 16..19 dropped.
  - No FILL; `last_len` = 16, `overflow` = 1, `slot_valid[0]` = 1.
- **Back-pressure:** `mem_wait` held high for 3 cycles on byte 2.
  - `mem_we`, `mem_addr` = 2 and data held stable for those cycles, with `ioctl_wait` high throughout.
  - Image is correct afterwards.
- **Empty and foreign downloads:**
  - Index 1 with zero bytes: 16 FILL writes, `slot_valid[0]` = 0, `last_len` = 0.
  - Index 5: no `mem_we`, and `busy` stays 0.
- **Reset mid-operation:** `reset` pulsed during FILL at address 12.
  - All outputs are 0 immediately (asynchronous).
  - No further writes; state is IDLE.
- **Write on the falling edge:** `ioctl_wr` at addr 3 in the same cycle `ioctl_download` falls.
  - Byte 3 is written first; FILL then starts at 4.
